multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multicycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback over several clocks, so one ALU and one memory port serve the whole instruction. It sits between the combinational instruction decoder and the shared datapath, and it alone gates every architectural write: IR, PC, register file and data memory. It also handles the memory ready handshakes, halts on EBREAK, traps on illegal opcodes and bus timeouts, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles for a memory ready; 0 disables the timeout.
- RETIRE_W, 32: width of the retired-instruction counter.

- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start/continue enable, sampled only at instruction boundaries.
- opcode  in  7  from the instruction register; valid from DECODE onward.
- br_taken  in  1  branch comparator result; valid in WRITEBACK.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  update the PC.
- pc_src  out  1  0 = PC+4, 1 = ALU target.
- ru_write_en  out  1  register file write strobe.
- dm_write_en  out  1  data memory write strobe.
- halted  out  1  core stopped (EBREAK or trap).
- illegal  out  1  stopped by an illegal opcode.
- bus_error  out  1  stopped by a memory timeout.
- instret  out  RETIRE_W  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP.
- IDLE: no outputs asserted. Go to FETCH when run=1.
- FETCH: imem_req=1.
  - When imem_ready=1: assert ir_write for that cycle, go to DECODE.
- DECODE: classify opcode.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
  - 1110011 (SYSTEM) -> HALT.
  - Any other non-legal opcode -> TRAP with illegal=1.
  - Otherwise -> EXECUTE.
- EXECUTE: one cycle for ALU settling.
  - Load (0000011) or store (0100011) -> MEM.
  - All other opcodes -> WRITEBACK.
- MEM: dmem_req=1; for a store, also dm_write_en=1.
  - When dmem_ready=1 on a load: go to WRITEBACK.
  - When dmem_ready=1 on a store: assert pc_write with pc_src=0 that cycle, retire the instruction, then go to FETCH (run=1) or IDLE (run=0).
- WRITEBACK: assert pc_write for one cycle.
  - ru_write_en=1 for R, I-ALU, load, JAL, JALR, LUI and AUIPC; 0 for branches.
  - pc_src=1 for JAL and JALR, br_taken for branches, 0 otherwise.
  - Next state: FETCH if run=1, else IDLE.
- HALT and TRAP: absorbing; only reset leaves them.
  - halted=1 in both states.
  - illegal and bus_error are sticky flags, cleared only by reset.
  - The stopping instruction does not retire.
- Memory timeout: a wait counter counts cycles spent in FETCH or MEM with ready low and clears on state entry. If it reaches MEM_TIMEOUT, go to TRAP with bus_error=1.
- instret: increments by one on every retirement, i.e. every pc_write pulse; wraps modulo 2^RETIRE_W.

## Timing
- Reset (asynchronous): state=IDLE, every output 0, instret=0, wait counter=0.
- Output types:
  - imem_req, dmem_req, dm_write_en, halted, illegal, bus_error: Moore, decoded from the state register.
  - ir_write: Mealy, gated by imem_ready.
  - store pc_write: Mealy, gated by dmem_ready.
  - All WRITEBACK strobes: asserted for the whole single WRITEBACK cycle.
- Every write strobe is at most one cycle wide per instruction.
- Latency with zero-wait memory (ready high in the first request cycle):
  - R/I/U/jump/branch: 4 cycles (F, D, E, WB).
  - Load: 5 cycles (F, D, E, M, WB).
  - Store: 4 cycles (F, D, E, M).
- Each wait cycle adds one cycle. A ready pulse outside FETCH or MEM is ignored.
- run=0 mid-instruction: the current instruction completes; the machine then parks in IDLE.
- Reset asserted mid-MEM: dmem_req and dm_write_en drop asynchronously; no partial retirement.
- Timeout boundary: with ready low, the TRAP transition occurs on the edge ending the MEM_TIMEOUT-th wait cycle.
  - Ready arriving in that same cycle wins, and the access completes normally.

## Test plan
- ADD, zero-wait memory, run=1 -> ir_write in cycle 1, ru_write_en and pc_write (pc_src=0) in cycle 4, instret=1.
- LW with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, WRITEBACK 1 cycle later, ru_write_en pulses once, total latency 8 cycles.
- SW, then BEQ with br_taken=1, then BNE with br_taken=0 -> dm_write_en only during MEM; pc_src 1 then 0; ru_write_en never asserted; instret=3.
- Opcode 0000000 -> TRAP at the end of DECODE; illegal=1, halted=1, instret unchanged. EBREAK -> halted=1, illegal=0.
- MEM_TIMEOUT=4, imem_ready held low -> bus_error=1 after 4 FETCH cycles. A repeat run with ready rising in cycle 4 -> normal fetch.
- Assert rst_n=0 during a store wait, and separately drop run mid-JAL -> all outputs 0 immediately on reset; JAL retires, then the machine sits in IDLE.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Handshake and control bundle between the multicycle sequencer and the
// rest of the RV32I core (instruction decoder, datapath, memories).
//   master : core side -- drives run/opcode/br_taken/ready, observes strobes
//   slave  : the sequencer -- observes inputs, drives request/write strobes,
//            status flags and the retired-instruction count
interface multicycle_sequencer_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic                run;
  logic [6:0]          opcode;
  logic                br_taken;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                dmem_req;
  logic                ir_write;
  logic                pc_write;
  logic                pc_src;
  logic                ru_write_en;
  logic                dm_write_en;
  logic                halted;
  logic                illegal;
  logic                bus_error;
  logic [RETIRE_W-1:0] instret;

  modport master (
    output run, opcode, br_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, ir_write, pc_write, pc_src, ru_write_en,
           dm_write_en, halted, illegal, bus_error, instret
  );

  modport slave (
    input  run, opcode, br_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, ir_write, pc_write, pc_src, ru_write_en,
           dm_write_en, halted, illegal, bus_error, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer for the RV32I core. Steps each instruction through
// FETCH, DECODE, EXECUTE, MEM and WRITEBACK so a single ALU and memory port
// serve the instruction, and gates every architectural write (IR, PC,
// register file, data memory). Halts on SYSTEM, traps on illegal opcodes and
// memory-ready timeouts, and counts retired instructions.
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of multicycle_sequencer_if (run/opcode/br_taken/
//            ready inputs; req/write strobes, halted/illegal/bus_error,
//            instret outputs)
// Parameters:
//   MEM_TIMEOUT : max wait cycles for a memory ready, 0 disables
//   RETIRE_W    : width of instret (must match the interface)
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned RETIRE_W    = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int unsigned WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned WAIT_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [RETIRE_W-1:0] instret_q;
  logic                illegal_q, bus_err_q;
  logic                set_illegal, set_bus_err;

  logic is_load, is_store, is_branch, is_jump, is_system, is_legal;
  logic timeout_hit;

  logic imem_req, dmem_req, ir_write, pc_write, pc_src, ru_write_en, dm_write_en;

  // opcode comes straight from the IR, so it stays stable from DECODE on
  always_comb begin
    is_load   = (bus.opcode == OP_LOAD);
    is_store  = (bus.opcode == OP_STORE);
    is_branch = (bus.opcode == OP_BRANCH);
    is_jump   = (bus.opcode == OP_JAL) || (bus.opcode == OP_JALR);
    is_system = (bus.opcode == OP_SYSTEM);
    is_legal  = is_load || is_store || is_branch || is_jump || is_system ||
                (bus.opcode == OP_R) || (bus.opcode == OP_I) ||
                (bus.opcode == OP_LUI) || (bus.opcode == OP_AUIPC);
  end

  // wait_cnt holds the number of completed wait cycles, so the trap fires on
  // the edge that ends the MEM_TIMEOUT-th one; a ready in that cycle wins
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(WAIT_LAST));

  always_comb begin
    state_nxt    = state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ru_write_en  = 1'b0;
    dm_write_en  = 1'b0;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.run) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_write  = 1'b1;
          state_nxt = DECODE;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_nxt   = TRAP;
        end
      end
      DECODE: begin
        if (!is_legal) begin
          set_illegal = 1'b1;
          state_nxt   = TRAP;
        end else if (is_system) begin
          state_nxt = HALT;
        end else begin
          state_nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        state_nxt = (is_load || is_store) ? MEM : WRITEBACK;
      end
      MEM: begin
        dmem_req    = 1'b1;
        dm_write_en = is_store;
        if (bus.dmem_ready) begin
          if (is_store) begin
            // stores retire here; there is no register writeback to do
            pc_write  = 1'b1;
            state_nxt = bus.run ? FETCH : IDLE;
          end else begin
            state_nxt = WRITEBACK;
          end
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_nxt   = TRAP;
        end
      end
      WRITEBACK: begin
        pc_write    = 1'b1;
        ru_write_en = !is_branch;
        pc_src      = is_jump || (is_branch && bus.br_taken);
        state_nxt   = bus.run ? FETCH : IDLE;
      end
      HALT, TRAP: begin
        state_nxt = state;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (state_nxt != state) begin
      wait_cnt_nxt = '0;
    end else if ((state == FETCH && !bus.imem_ready) ||
                 (state == MEM   && !bus.dmem_ready)) begin
      wait_cnt_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (pc_write)    instret_q <= instret_q + 1'b1;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.dmem_req    = dmem_req;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.ru_write_en = ru_write_en;
  assign bus.dm_write_en = dm_write_en;
  assign bus.halted      = (state == HALT) || (state == TRAP);
  assign bus.illegal     = illegal_q;
  assign bus.bus_error   = bus_err_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (MEM_TIMEOUT overridden to 4).
// Each retiring instruction pushes its expected retirement record (register
// write, PC source, latency from first fetch cycle) to a scoreboard; a
// monitor pops and compares on every pc_write pulse.
module tb_multicycle_sequencer;

  localparam int unsigned TO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct {
    logic        ru;
    logic        src;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_sequencer_if #(.RETIRE_W(32)) bus_if ();

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .RETIRE_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // retirement monitor
  int unsigned cyc = 0;
  int unsigned fstart = 0;
  logic        prev_ireq = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ireq = 1'b0;
    end else begin
      exp_t e;
      cyc++;
      if (bus_if.imem_req && !prev_ireq) fstart = cyc;
      prev_ireq = bus_if.imem_req;
      if (bus_if.ru_write_en) chk("ru_only_with_pc", 32'(bus_if.pc_write), 32'd1);
      if (bus_if.pc_write) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("retire_ru_write_en", 32'(bus_if.ru_write_en), 32'(e.ru));
          chk("retire_pc_src", 32'(bus_if.pc_src), 32'(e.src));
          chk("retire_latency", cyc - fstart + 1, e.lat);
        end
      end
    end
  end

  // per-instruction observation counts and stop timing
  int n_ir, n_dreq, n_dwe, n_ru, first_req, stop_c;
  logic done;

  // Entered and left at posedge+1. Drives one instruction; memories answer
  // after iwait/dwait request cycles. Stops at retirement, halt or budget.
  task automatic exec(input logic [6:0] op, input logic br, input int iwait,
                      input int dwait, input logic run_after,
                      input logic expect_retire, input int budget);
    int ic = 0;
    int dc = 0;
    logic is_ld = (op == OP_LOAD);
    logic is_st = (op == OP_STORE);
    n_ir = 0; n_dreq = 0; n_dwe = 0; n_ru = 0;
    first_req = -1; stop_c = -1; done = 1'b0;
    bus_if.opcode   = op;
    bus_if.br_taken = br;
    if (expect_retire)
      sb.push_back('{ru: !(is_st || op == OP_BRANCH),
                     src: (op == OP_JAL) || (op == OP_BRANCH && br),
                     lat: 4 + iwait + ((is_ld || is_st) ? dwait : 0) + (is_ld ? 1 : 0)});
    for (int c = 0; c < budget; c++) begin
      bus_if.run = (c == 0) ? 1'b1 : run_after;
      bus_if.imem_ready = bus_if.imem_req && (ic == iwait);
      if (bus_if.imem_req) ic++;
      bus_if.dmem_ready = bus_if.dmem_req && (dc == dwait);
      if (bus_if.dmem_req) dc++;
      @(negedge clk);
      if (bus_if.imem_req && first_req < 0) first_req = c;
      if (bus_if.ir_write)    n_ir++;
      if (bus_if.dmem_req)    n_dreq++;
      if (bus_if.dm_write_en) n_dwe++;
      if (bus_if.ru_write_en) n_ru++;
      if (bus_if.pc_write || bus_if.halted) begin
        done = 1'b1;
        stop_c = c;
      end
      @(posedge clk);
      #1;
      if (done) break;
    end
    bus_if.imem_ready = 1'b0;
    bus_if.dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.run = 1'b0;
    bus_if.imem_ready = 1'b0;
    bus_if.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_imem_req"}, 32'(bus_if.imem_req), 32'd0);
    chk({tag, "_dmem_req"}, 32'(bus_if.dmem_req), 32'd0);
    chk({tag, "_dm_write_en"}, 32'(bus_if.dm_write_en), 32'd0);
    chk({tag, "_pc_write"}, 32'(bus_if.pc_write), 32'd0);
  endtask

  initial begin
    bus_if.run = 1'b0;
    bus_if.opcode = 7'd0;
    bus_if.br_taken = 1'b0;
    bus_if.imem_ready = 1'b0;
    bus_if.dmem_ready = 1'b0;
    #2;
    // reset state, checked while reset is held
    chk_quiet("rst");
    chk("rst_ir_write", 32'(bus_if.ir_write), 32'd0);
    chk("rst_ru_write_en", 32'(bus_if.ru_write_en), 32'd0);
    chk("rst_halted", 32'(bus_if.halted), 32'd0);
    chk("rst_illegal", 32'(bus_if.illegal), 32'd0);
    chk("rst_bus_error", 32'(bus_if.bus_error), 32'd0);
    chk("rst_instret", bus_if.instret, 32'd0);
    do_reset();

    // ADD, zero wait
    exec(OP_R, 1'b0, 0, 0, 1'b1, 1'b1, 20);
    chk("add_done", 32'(done), 32'd1);
    chk("add_ir_write_count", 32'(n_ir), 32'd1);
    chk("add_ru_count", 32'(n_ru), 32'd1);
    chk("add_instret", bus_if.instret, 32'd1);

    // LW, data ready on the 4th request cycle (timeout boundary, ready wins)
    exec(OP_LOAD, 1'b0, 0, 3, 1'b1, 1'b1, 30);
    chk("lw_dmem_req_cycles", 32'(n_dreq), 32'd4);
    chk("lw_dm_write_en_cycles", 32'(n_dwe), 32'd0);
    chk("lw_ru_count", 32'(n_ru), 32'd1);
    chk("lw_bus_error", 32'(bus_if.bus_error), 32'd0);

    // SW, BEQ taken, BNE not taken
    exec(OP_STORE, 1'b0, 0, 0, 1'b1, 1'b1, 20);
    chk("sw_dm_write_en_cycles", 32'(n_dwe), 32'd1);
    chk("sw_dmem_req_cycles", 32'(n_dreq), 32'd1);
    chk("sw_ru_count", 32'(n_ru), 32'd0);
    exec(OP_BRANCH, 1'b1, 0, 0, 1'b1, 1'b1, 20);
    chk("beq_ru_count", 32'(n_ru), 32'd0);
    exec(OP_BRANCH, 1'b0, 0, 0, 1'b1, 1'b1, 20);
    chk("bne_ru_count", 32'(n_ru), 32'd0);
    chk("branch_dm_write_en", 32'(n_dwe), 32'd0);
    chk("seq_instret", bus_if.instret, 32'd5);

    // ADDI with fetch ready on the 4th request cycle: normal fetch
    exec(OP_I, 1'b0, 3, 0, 1'b1, 1'b1, 30);
    chk("addi_slow_fetch_ir", 32'(n_ir), 32'd1);
    chk("addi_slow_fetch_halted", 32'(bus_if.halted), 32'd0);

    // JAL with run dropped mid-instruction: retires, then parks in IDLE
    exec(OP_JAL, 1'b0, 0, 0, 1'b0, 1'b1, 20);
    chk("jal_instret", bus_if.instret, 32'd7);
    repeat (3) @(negedge clk);
    chk_quiet("idle_after_jal");
    chk("idle_instret", bus_if.instret, 32'd7);
    @(posedge clk);
    #1;

    // store stalled in MEM, then asynchronous reset
    exec(OP_STORE, 1'b0, 0, 50, 1'b1, 1'b0, 5);
    chk("sw_stall_dmem_req", 32'(bus_if.dmem_req), 32'd1);
    chk("sw_stall_dm_write_en", 32'(bus_if.dm_write_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_instret", bus_if.instret, 32'd0);
    do_reset();

    // illegal opcode after one good instruction
    exec(OP_R, 1'b0, 0, 0, 1'b1, 1'b1, 20);
    exec(7'b0000000, 1'b0, 0, 0, 1'b1, 1'b0, 20);
    chk("illegal_stop_cycles", 32'(stop_c - first_req), 32'd2);
    chk("illegal_flag", 32'(bus_if.illegal), 32'd1);
    chk("illegal_halted", 32'(bus_if.halted), 32'd1);
    chk("illegal_bus_error", 32'(bus_if.bus_error), 32'd0);
    chk("illegal_instret", bus_if.instret, 32'd1);
    repeat (4) @(negedge clk);
    chk("trap_absorbing", 32'(bus_if.halted), 32'd1);
    chk_quiet("trap");
    do_reset();

    // EBREAK
    exec(OP_SYSTEM, 1'b0, 0, 0, 1'b1, 1'b0, 20);
    chk("ebreak_stop_cycles", 32'(stop_c - first_req), 32'd2);
    chk("ebreak_halted", 32'(bus_if.halted), 32'd1);
    chk("ebreak_illegal", 32'(bus_if.illegal), 32'd0);
    chk("ebreak_instret", bus_if.instret, 32'd0);
    do_reset();

    // fetch timeout: imem_ready never rises
    exec(OP_R, 1'b0, 1000, 0, 1'b1, 1'b0, 30);
    chk("timeout_done", 32'(done), 32'd1);
    chk("timeout_stop_cycles", 32'(stop_c - first_req), TO);
    chk("timeout_bus_error", 32'(bus_if.bus_error), 32'd1);
    chk("timeout_illegal", 32'(bus_if.illegal), 32'd0);
    chk("timeout_halted", 32'(bus_if.halted), 32'd1);
    chk("timeout_ir_write", 32'(n_ir), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
